// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall/flush responder for the hazard detection unit.
// Turns data_hazard / PC_hazard into PC and IF_ID write enables, IF_ID flush
// and ID_EX bubble, pulses PC_update when a ret/call target is valid, and
// keeps saturating stall counters plus a stuck-data-stall watchdog.
module pipe_stall_ctrl #(
  parameter int CTRL_LAT   = 3,
  parameter int DSTALL_MAX = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_hazard,
  input  logic             PC_hazard,
  input  logic             cnt_clr,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             PC_update,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] data_stall_cnt,
  output logic [CNT_W-1:0] ctrl_stall_cnt
);

  localparam int WCNT_W = (CTRL_LAT > 1) ? $clog2(CTRL_LAT) : 1;
  localparam int RUN_W  = $clog2(DSTALL_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_DSTALL,
    S_CTRL_WAIT,
    S_RESOLVE
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [RUN_W-1:0]  run_q;
  logic              data_stall;  // data-stall outputs driven this cycle
  logic              ctrl_stall;  // acceptance, CTRL_WAIT or RESOLVE cycle

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic; PC_hazard outranks data_hazard, RESOLVE ignores both.
  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_INIT: state_d = S_RUN;
      S_RUN, S_DSTALL: begin
        if (PC_hazard) begin
          // With a one-cycle latency the target is valid on the very next cycle.
          state_d = (CTRL_LAT == 1) ? S_RESOLVE : S_CTRL_WAIT;
          wcnt_d  = WCNT_W'(CTRL_LAT - 1);
        end else if (data_hazard) begin
          state_d = S_DSTALL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CTRL_WAIT: begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q <= WCNT_W'(1)) state_d = S_RESOLVE;
      end
      S_RESOLVE: state_d = S_RUN;
      default:   state_d = S_INIT;
    endcase
  end

  // Pipeline controls: Mealy in RUN/DSTALL so a stall acts in the raising cycle.
  always_comb begin
    PC_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    PC_update    = 1'b0;
    data_stall   = 1'b0;
    ctrl_stall   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
      S_RUN, S_DSTALL: begin
        if (PC_hazard) begin
          IF_ID_write = 1'b1;
          IF_ID_flush = 1'b1;
          ctrl_stall  = 1'b1;
        end else if (data_hazard) begin
          ID_EX_bubble = 1'b1;
          data_stall   = 1'b1;
        end else begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
      end
      S_CTRL_WAIT: begin
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b1;
        ctrl_stall  = 1'b1;
      end
      S_RESOLVE: begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b1;
        PC_update   = 1'b1;
        ctrl_stall  = 1'b1;
      end
      default: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
    endcase
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_stall_cnt <= '0;
      ctrl_stall_cnt <= '0;
    end else if (cnt_clr) begin
      data_stall_cnt <= '0;
      ctrl_stall_cnt <= '0;
    end else begin
      if (data_stall && (data_stall_cnt != '1)) data_stall_cnt <= data_stall_cnt + 1'b1;
      if (ctrl_stall && (ctrl_stall_cnt != '1)) ctrl_stall_cnt <= ctrl_stall_cnt + 1'b1;
    end
  end

  // Watchdog: length of the current data-stall run, held at DSTALL_MAX so the
  // sticky flag fires once per run, on the cycle the run reaches the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else if (!data_stall) begin
      run_q <= '0;
    end else if (run_q != RUN_W'(DSTALL_MAX)) begin
      run_q <= run_q + 1'b1;
    end
  end

  // Sticky timeout flag; only cnt_clr or reset lowers it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_timeout <= 1'b0;
    end else if (cnt_clr) begin
      stall_timeout <= 1'b0;
    end else if (data_stall && (run_q == RUN_W'(DSTALL_MAX - 1))) begin
      stall_timeout <= 1'b1;
    end
  end

endmodule
